// File: rtl/mipi_raw10_unpacker_if.sv
// Byte-in / pixel-out bundle for the RAW10 unpacker.
// The master drives the payload byte stream, and the slave returns the pixel stream.
interface mipi_raw10_unpacker_if #(
    parameter int LINE_CNT_W = 16
);
    logic                  byte_valid_i;
    logic [7:0]            byte_i;
    logic                  line_start_i;
    logic                  line_end_i;
    logic                  err_clr_i;

    logic                  pix_valid_o;
    logic [9:0]            pix_o;
    logic                  pix_sol_o;
    logic                  pix_eol_o;
    logic [LINE_CNT_W-1:0] line_len_o;
    logic                  err_o;

    modport master (
        output byte_valid_i,
        output byte_i,
        output line_start_i,
        output line_end_i,
        output err_clr_i,
        input  pix_valid_o,
        input  pix_o,
        input  pix_sol_o,
        input  pix_eol_o,
        input  line_len_o,
        input  err_o
    );

    modport slave (
        input  byte_valid_i,
        input  byte_i,
        input  line_start_i,
        input  line_end_i,
        input  err_clr_i,
        output pix_valid_o,
        output pix_o,
        output pix_sol_o,
        output pix_eol_o,
        output line_len_o,
        output err_o
    );
endinterface

// File: rtl/mipi_raw10_unpacker.sv
// MIPI CSI-2 RAW10 unpacker: 5-byte groups become 4 ten-bit pixels.
// Tracks line start/end, line length and sticky framing errors.
module mipi_raw10_unpacker #(
    parameter int LINE_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    mipi_raw10_unpacker_if.slave   bus
);

    typedef struct packed {
        logic       sol;
        logic       eol;
        logic [9:0] pix;
    } ent_t;

    logic [2:0]            r_bcnt;
    logic [7:0]            r_msb [4];
    logic                  r_sol_pend;
    ent_t                  r_buf [4];
    logic [2:0]            r_ocnt;
    logic [LINE_CNT_W-1:0] r_lcnt;
    logic [LINE_CNT_W-1:0] r_line_len;
    logic                  r_err;

    logic                  w_acc;
    logic                  w_start;
    logic                  w_end;
    logic [2:0]            w_bpos;
    logic                  w_load;
    logic                  w_end_err;
    logic                  w_err_set;
    logic                  w_emit;
    logic                  w_emit_sol;
    logic                  w_emit_eol;
    logic [LINE_CNT_W-1:0] w_lcnt_inc;

    assign w_acc      = bus.byte_valid_i;
    assign w_start    = w_acc & bus.line_start_i;
    assign w_end      = w_acc & bus.line_end_i;
    // A start byte always lands in slot 0, whatever was pending
    assign w_bpos     = w_start ? 3'd0 : r_bcnt;
    assign w_load     = w_acc & (w_bpos == 3'd4);
    assign w_end_err  = w_end & (w_bpos != 3'd4);
    assign w_err_set  = (w_start & (r_bcnt != 3'd0)) | w_end_err;

    assign w_emit     = (r_ocnt != 3'd0);
    assign w_emit_sol = w_emit & r_buf[0].sol;
    assign w_emit_eol = w_emit & r_buf[0].eol;
    assign w_lcnt_inc = (&r_lcnt) ? r_lcnt : r_lcnt + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bcnt     <= 3'd0;
            r_sol_pend <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                r_msb[k] <= 8'h00;
            end
        end else if (w_acc) begin
            if (w_load || w_end_err) begin
                r_bcnt     <= 3'd0;
                r_sol_pend <= 1'b0;
            end else begin
                r_msb[w_bpos[1:0]] <= bus.byte_i;
                r_bcnt             <= w_bpos + 3'd1;
                if (w_start) begin
                    r_sol_pend <= 1'b1;
                end
            end
        end
    end

    // Group buffer drains from slot 0; tags ride with their pixels
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ocnt <= 3'd0;
            for (int k = 0; k < 4; k++) begin
                r_buf[k] <= '0;
            end
        end else if (w_load) begin
            r_ocnt <= 3'd4;
            for (int k = 0; k < 4; k++) begin
                r_buf[k].sol <= (k == 0) && r_sol_pend;
                r_buf[k].eol <= (k == 3) && bus.line_end_i;
                r_buf[k].pix <= {r_msb[k], bus.byte_i[2*k +: 2]};
            end
        end else if (w_emit) begin
            r_ocnt <= r_ocnt - 3'd1;
            for (int k = 0; k < 3; k++) begin
                r_buf[k] <= r_buf[k+1];
            end
            r_buf[3] <= '0;
        end
    end

    // Counting restarts on the SOL pixel so a start byte never disturbs the
    // tail of the previous line still draining.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lcnt     <= '0;
            r_line_len <= '0;
        end else if (w_emit_eol) begin
            r_lcnt     <= '0;
            r_line_len <= w_lcnt_inc;
        end else if (w_end_err) begin
            r_lcnt <= '0;
        end else if (w_emit_sol) begin
            r_lcnt <= {{(LINE_CNT_W-1){1'b0}}, 1'b1};
        end else if (w_start && !w_emit) begin
            r_lcnt <= '0;
        end else if (w_emit) begin
            r_lcnt <= w_lcnt_inc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_err_set) begin
            r_err <= 1'b1;
        end else if (bus.err_clr_i) begin
            r_err <= 1'b0;
        end
    end

    assign bus.pix_valid_o = w_emit;
    assign bus.pix_o       = w_emit ? r_buf[0].pix : 10'd0;
    assign bus.pix_sol_o   = w_emit_sol;
    assign bus.pix_eol_o   = w_emit_eol;
    assign bus.line_len_o  = r_line_len;
    assign bus.err_o       = r_err;

endmodule

// File: tb/tb_mipi_raw10_unpacker.sv
// Self-checking bench for mipi_raw10_unpacker.
// It applies a table of per-cycle vectors, then runs full lines and a mid-drain reset.
module tb_mipi_raw10_unpacker;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mipi_raw10_unpacker_if bus ();

    mipi_raw10_unpacker dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        v;
        logic [7:0]  b;
        logic        s;
        logic        e;
        logic        c;
        logic        pv;
        logic [9:0]  pix;
        logic        sol;
        logic        eol;
        logic        err;
        logic [15:0] len;
    } vec_t;

    vec_t tab [37];
    int n_chk  = 0;
    int n_fail = 0;

    logic [11:0] cap [$];
    logic        cap_en = 1'b0;

    always @(posedge clk) begin
        #1;
        if (cap_en && bus.pix_valid_o)
            cap.push_back({bus.pix_sol_o, bus.pix_eol_o, bus.pix_o});
    end

    function automatic vec_t mk(logic v, logic [7:0] b, logic s, logic e,
                                logic c, logic pv, logic [9:0] pix,
                                logic sol, logic eol, logic err,
                                logic [15:0] len);
        vec_t r;
        r.v = v; r.b = b; r.s = s; r.e = e; r.c = c;
        r.pv = pv; r.pix = pix; r.sol = sol; r.eol = eol;
        r.err = err; r.len = len;
        return r;
    endfunction

    function automatic logic [9:0] pval(int i);
        return 10'((i * 37 + 5) % 1024);
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(logic v, logic [7:0] b, logic s, logic e, logic c);
        @(negedge clk);
        bus.byte_valid_i = v;
        bus.byte_i       = b;
        bus.line_start_i = s;
        bus.line_end_i   = e;
        bus.err_clr_i    = c;
    endtask

    task automatic run_rows(int lo, int hi);
        for (int i = lo; i <= hi; i++) begin
            drive(tab[i].v, tab[i].b, tab[i].s, tab[i].e, tab[i].c);
            @(posedge clk);
            #1;
            chk($sformatf("row%0d pv", i),  32'(bus.pix_valid_o), 32'(tab[i].pv));
            chk($sformatf("row%0d pix", i), 32'(bus.pix_o),       32'(tab[i].pix));
            chk($sformatf("row%0d sol", i), 32'(bus.pix_sol_o),   32'(tab[i].sol));
            chk($sformatf("row%0d eol", i), 32'(bus.pix_eol_o),   32'(tab[i].eol));
            chk($sformatf("row%0d err", i), 32'(bus.err_o),       32'(tab[i].err));
            chk($sformatf("row%0d len", i), 32'(bus.line_len_o),  32'(tab[i].len));
        end
    endtask

    task automatic send_line(bit gaps);
        logic [9:0] p [4];
        logic [7:0] b;
        cap.delete();
        cap_en = 1'b1;
        for (int g = 0; g < 160; g++) begin
            for (int k = 0; k < 4; k++) p[k] = pval(g * 4 + k);
            for (int k = 0; k < 5; k++) begin
                if (gaps) begin
                    repeat ($urandom_range(0, 2)) drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
                end
                if (k < 4) b = p[k][9:2];
                else       b = {p[3][1:0], p[2][1:0], p[1][1:0], p[0][1:0]};
                drive(1'b1, b, (g == 0) && (k == 0), (g == 159) && (k == 4), 1'b0);
            end
        end
        repeat (8) drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        cap_en = 1'b0;
    endtask

    task automatic check_line(string nm);
        logic [11:0] exp;
        int n;
        n = cap.size();
        chk({nm, " count"}, 32'(n), 32'd640);
        if (n > 640) n = 640;
        for (int i = 0; i < n; i++) begin
            exp = {i == 0, i == 639, pval(i)};
            chk($sformatf("%s px%0d", nm, i), 32'(cap[i]), 32'(exp));
        end
        chk({nm, " len"}, 32'(bus.line_len_o), 32'd640);
        chk({nm, " err"}, 32'(bus.err_o), 32'd0);
    endtask

    initial begin
        // single clean line of one group
        tab[0]  = mk(1, 8'h12, 1, 0, 0, 0, 10'h000, 0, 0, 0, 0);
        tab[1]  = mk(1, 8'h34, 0, 0, 0, 0, 10'h000, 0, 0, 0, 0);
        tab[2]  = mk(1, 8'h56, 0, 0, 0, 0, 10'h000, 0, 0, 0, 0);
        tab[3]  = mk(1, 8'h78, 0, 0, 0, 0, 10'h000, 0, 0, 0, 0);
        tab[4]  = mk(1, 8'hE4, 0, 1, 0, 1, 10'h048, 1, 0, 0, 0);
        tab[5]  = mk(0, 8'h00, 0, 0, 0, 1, 10'h0D1, 0, 0, 0, 0);
        tab[6]  = mk(0, 8'h00, 0, 0, 0, 1, 10'h15A, 0, 0, 0, 0);
        tab[7]  = mk(0, 8'h00, 0, 0, 0, 1, 10'h1E3, 0, 1, 0, 0);
        tab[8]  = mk(0, 8'h00, 0, 0, 0, 0, 10'h000, 0, 0, 0, 4);
        // end on 3rd byte, then clear; start+end on one byte
        tab[9]  = mk(1, 8'h01, 1, 0, 0, 0, 10'h000, 0, 0, 0, 4);
        tab[10] = mk(1, 8'h02, 0, 0, 0, 0, 10'h000, 0, 0, 0, 4);
        tab[11] = mk(1, 8'h03, 0, 1, 0, 0, 10'h000, 0, 0, 1, 4);
        tab[12] = mk(0, 8'h00, 0, 0, 0, 0, 10'h000, 0, 0, 1, 4);
        tab[13] = mk(0, 8'h00, 0, 0, 1, 0, 10'h000, 0, 0, 0, 4);
        tab[14] = mk(1, 8'h55, 1, 1, 0, 0, 10'h000, 0, 0, 1, 4);
        tab[15] = mk(0, 8'h00, 0, 0, 0, 0, 10'h000, 0, 0, 1, 4);
        tab[16] = mk(0, 8'h00, 0, 0, 1, 0, 10'h000, 0, 0, 0, 4);
        // restart after 2 bytes; clear collides with a new error
        tab[17] = mk(1, 8'h10, 1, 0, 0, 0, 10'h000, 0, 0, 0, 4);
        tab[18] = mk(1, 8'h20, 0, 0, 0, 0, 10'h000, 0, 0, 0, 4);
        tab[19] = mk(1, 8'h40, 1, 0, 0, 0, 10'h000, 0, 0, 1, 4);
        tab[20] = mk(1, 8'h80, 0, 0, 0, 0, 10'h000, 0, 0, 1, 4);
        tab[21] = mk(1, 8'hC0, 0, 0, 0, 0, 10'h000, 0, 0, 1, 4);
        tab[22] = mk(1, 8'h00, 0, 0, 0, 0, 10'h000, 0, 0, 1, 4);
        tab[23] = mk(1, 8'hFF, 0, 0, 0, 1, 10'h103, 1, 0, 1, 4);
        tab[24] = mk(1, 8'h00, 1, 1, 1, 1, 10'h203, 0, 0, 1, 4);
        tab[25] = mk(0, 8'h00, 0, 0, 0, 1, 10'h303, 0, 0, 1, 4);
        tab[26] = mk(0, 8'h00, 0, 0, 0, 1, 10'h003, 0, 0, 1, 4);
        tab[27] = mk(0, 8'h00, 0, 0, 1, 0, 10'h000, 0, 0, 0, 4);
        // first group after reset, no start byte: unpacked but untagged
        tab[28] = mk(1, 8'h12, 0, 0, 0, 0, 10'h000, 0, 0, 0, 0);
        tab[29] = mk(1, 8'h34, 0, 0, 0, 0, 10'h000, 0, 0, 0, 0);
        tab[30] = mk(1, 8'h56, 0, 0, 0, 0, 10'h000, 0, 0, 0, 0);
        tab[31] = mk(1, 8'h78, 0, 0, 0, 0, 10'h000, 0, 0, 0, 0);
        tab[32] = mk(1, 8'hE4, 0, 0, 0, 1, 10'h048, 0, 0, 0, 0);
        tab[33] = mk(0, 8'h00, 0, 0, 0, 1, 10'h0D1, 0, 0, 0, 0);
        tab[34] = mk(0, 8'h00, 0, 0, 0, 1, 10'h15A, 0, 0, 0, 0);
        tab[35] = mk(0, 8'h00, 0, 0, 0, 1, 10'h1E3, 0, 0, 0, 0);
        tab[36] = mk(0, 8'h00, 0, 0, 0, 0, 10'h000, 0, 0, 0, 0);

        rst = 1'b1;
        bus.byte_valid_i = 1'b0;
        bus.byte_i       = 8'h00;
        bus.line_start_i = 1'b0;
        bus.line_end_i   = 1'b0;
        bus.err_clr_i    = 1'b0;
        #1;
        chk("reset pv",  32'(bus.pix_valid_o), 32'd0);
        chk("reset pix", 32'(bus.pix_o),       32'd0);
        chk("reset sol", 32'(bus.pix_sol_o),   32'd0);
        chk("reset eol", 32'(bus.pix_eol_o),   32'd0);
        chk("reset len", 32'(bus.line_len_o),  32'd0);
        chk("reset err", 32'(bus.err_o),       32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        run_rows(0, 27);

        send_line(1'b0);
        check_line("line640");
        send_line(1'b1);
        check_line("gaps640");

        // reset while px2 of a group is on the output
        drive(1'b1, 8'h12, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 8'h34, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 8'h56, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 8'h78, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 8'hE4, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("pre-reset px2", 32'(bus.pix_o), 32'h15A);
        chk("pre-reset pv",  32'(bus.pix_valid_o), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid-drain rst pv",  32'(bus.pix_valid_o), 32'd0);
        chk("mid-drain rst pix", 32'(bus.pix_o),       32'd0);
        chk("mid-drain rst eol", 32'(bus.pix_eol_o),   32'd0);
        chk("mid-drain rst len", 32'(bus.line_len_o),  32'd0);
        chk("mid-drain rst err", 32'(bus.err_o),       32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        run_rows(28, 36);
        run_rows(0, 8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mipi_raw10_unpacker.md
# mipi_raw10_unpacker

Converts the MIPI CSI-2 RAW10 payload byte stream from the CSI RX packet decoder into 10-bit pixels for the ISP lane input. It reassembles each 5-byte RAW10 group (4 MSB bytes plus 1 LSB byte) into 4 pixels and marks line start and line end. It also counts pixels per line and flags malformed lines. One instance sits per CSI lane, between the packet decoder and the ISP.

## Interface
- `LINE_CNT_W`, default 16: width of the per-line pixel counter and `line_len_o`.
- `clk` in 1: pixel/byte clock; all logic on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `byte_valid_i` in 1: `byte_i` carries a payload byte this cycle.
- `byte_i` in 8: RAW10 payload byte.
- `line_start_i` in 1: first payload byte of a long packet; qualified by `byte_valid_i`.
- `line_end_i` in 1: last payload byte of a long packet; qualified by `byte_valid_i`.
- `err_clr_i` in 1: clears `err_o`.
- `pix_valid_o` out 1: `pix_o` valid.
- `pix_o` out 10: unpacked pixel.
- `pix_sol_o` out 1: with `pix_valid_o`, first pixel of line.
- `pix_eol_o` out 1: with `pix_valid_o`, last pixel of line.
- `line_len_o` out `LINE_CNT_W`: pixel count of the last completed line.
- `err_o` out 1: sticky framing error.

## Operation
- Group byte counter `bcnt` runs 0..4 and advances only on `byte_valid_i`.
  - At `bcnt` 0..3, the byte is stored as the MSBs of px0..px3.
  - At `bcnt` 4, the LSB byte is accepted and `bcnt` wraps to 0.
- Pixel formation on the LSB byte:
  - px0 = {msb0, lsb[1:0]}
  - px1 = {msb1, lsb[3:2]}
  - px2 = {msb2, lsb[5:4]}
  - px3 = {msb3, lsb[7:6]}
  - All four are loaded into a 4-entry output buffer with `ocnt`=4.
- Output drain: while `ocnt`≠0, one pixel per cycle is emitted in order px0..px3. No backpressure. A group takes ≥5 input cycles and drains in 4, so the buffer is always empty when the next group loads.
- `line_start_i`:
  - The byte is taken as byte 0 (`bcnt` forced to 0 before storing).
  - If `bcnt`≠0 (partial group pending), that partial group is discarded and `err_o` is set.
  - The next completed group is tagged SOL.
  - The line pixel counter is reset.
- `line_end_i`:
  - Must coincide with `bcnt`=4. The group is tagged EOL; `pix_eol_o` fires on its px3.
  - On that px3, `line_len_o` <= line counter + 1, and the counter clears.
  - If `line_end_i` arrives with `bcnt`≠4, the partial group is discarded, `bcnt`→0, `err_o` is set, `line_len_o` is unchanged, and the counter clears.
- `line_start_i` and `line_end_i` on the same byte:
  - Treated as a start immediately followed by an end.
  - Always an error, because `bcnt`=0≠4.
  - Nothing is emitted.
- The line pixel counter increments on every emitted pixel and saturates at all-ones.
- `err_o` is sticky until `err_clr_i`. If set and clear happen in the same cycle, set wins.
- A line start arriving while the previous group is still draining does not disturb the drain. SOL/EOL tags travel with their own buffered group.

## Timing
- Reset values:
  - `pix_valid_o`, `pix_sol_o`, `pix_eol_o`, `err_o` = 0
  - `pix_o` = 0, `line_len_o` = 0
  - `bcnt`, `ocnt`, line counter = 0
  - SOL/EOL pending flags cleared
- Latency: px0 is registered out on the cycle after the LSB byte is accepted (1 cycle). px1..px3 follow on the 3 consecutive cycles.
- Gaps in `byte_valid_i` are allowed anywhere. `bcnt` and stored MSBs hold. A drain in progress continues regardless of input.
- `pix_sol_o` and `pix_eol_o` are only ever high together with `pix_valid_o`. Both are high on px0 only when the line is 4 pixels long… no: SOL is on px0 and EOL on px3, so both can never be high on the same pixel.
- Reset asserted mid-line or mid-drain: all outputs drop asynchronously and the partial group is lost. The first group after release needs no `line_start_i` to be unpacked, but it is not SOL-tagged.

## Test plan
- Single group: `line_start_i` on 0x12, then 0x34, 0x56, 0x78, then 0xE4 with `line_end_i` -> pixels 0x048 (SOL), 0x0D1, 0x15A, 0x1E3 (EOL) on 4 consecutive cycles starting 1 cycle after 0xE4; `line_len_o`=4; `err_o`=0.
- Back-to-back line of 640 px (800 bytes, `byte_valid_i` always high) -> 640 pixels, SOL on the first, EOL on the last, no pixel dropped or duplicated; `line_len_o`=640.
- Random `byte_valid_i` gaps (50% duty) on the same line -> identical pixel sequence and values as the gap-free run.
- `line_end_i` on the 3rd byte of a group -> partial group discarded, no pixel output, `err_o`=1, `line_len_o` unchanged; `err_clr_i` -> `err_o`=0.
- New `line_start_i` after 2 bytes of a pending group -> `err_o`=1; the next 5 bytes yield a correct SOL-tagged group; `err_clr_i` asserted in the same cycle as a new error -> `err_o` stays 1.
- Reset asserted during px2 of a drain -> `pix_valid_o`=0 immediately, all counters 0; a following clean line unpacks correctly.
